regfile_sb: RTL and testbench

Parametrised multi-port register file with an integrated scoreboard, for the next-generation datapath.
- Two write ports (ALU writeback and load writeback) and two combinational read ports.
- Optional same-cycle write-to-read bypass.
- Per-register pending (busy) bits, set on issue and cleared on writeback, so the issue stage can stall on RAW/WAW hazards.
- Register 0 reads as zero, is never writable and is never busy.

---
 rtl/regfile_sb.sv | 84 ++++++++
 tb/tb_regfile_sb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register pending scoreboard.
// r0 is hardwired to zero and never busy; wr1 wins over wr0 on address collisions.
module regfile_sb #(
    parameter int XLEN   = 16,
    parameter int NREGS  = 16,
    parameter int AW     = $clog2(NREGS),
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr0_en,
    input  logic [AW-1:0]    wr0_addr,
    input  logic [XLEN-1:0]  wr0_data,
    input  logic             wr1_en,
    input  logic [AW-1:0]    wr1_addr,
    input  logic [XLEN-1:0]  wr1_data,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_rdata,
    output logic [XLEN-1:0]  rs2_rdata,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_busy,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wr0_ok;
    logic             wr1_ok;

    assign wr0_ok = wr0_en && (wr0_addr != '0);
    assign wr1_ok = wr1_en && (wr1_addr != '0);

    // A forwarded write only matters for non-zero read addresses and only when bypass is built in.
    function automatic logic fwd_hit(input logic en, input logic [AW-1:0] wa, input logic [AW-1:0] ra);
        return (BYPASS != 0) && en && (wa == ra) && (ra != '0);
    endfunction

    // Clears are applied before the set so a same-cycle reissue stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (wr0_ok) busy_d[wr0_addr] = 1'b0;
        if (wr1_ok) busy_d[wr1_addr] = 1'b0;
        if (iss_en && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            if (wr0_ok) regs_q[wr0_addr] <= wr0_data;
            if (wr1_ok) regs_q[wr1_addr] <= wr1_data;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs1_rdata = '0;
        if (rs1_addr != '0) rs1_rdata = regs_q[rs1_addr];
        if (fwd_hit(wr0_en, wr0_addr, rs1_addr)) rs1_rdata = wr0_data;
        if (fwd_hit(wr1_en, wr1_addr, rs1_addr)) rs1_rdata = wr1_data;

        rs2_rdata = '0;
        if (rs2_addr != '0) rs2_rdata = regs_q[rs2_addr];
        if (fwd_hit(wr0_en, wr0_addr, rs2_addr)) rs2_rdata = wr0_data;
        if (fwd_hit(wr1_en, wr1_addr, rs2_addr)) rs2_rdata = wr1_data;

        rs1_busy = busy_q[rs1_addr] && !fwd_hit(wr0_en, wr0_addr, rs1_addr)
                                    && !fwd_hit(wr1_en, wr1_addr, rs1_addr);
        rs2_busy = busy_q[rs2_addr] && !fwd_hit(wr0_en, wr0_addr, rs2_addr)
                                    && !fwd_hit(wr1_en, wr1_addr, rs2_addr);
        rd_busy  = busy_q[iss_rd]   && !fwd_hit(wr0_en, wr0_addr, iss_rd)
                                    && !fwd_hit(wr1_en, wr1_addr, iss_rd);
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus
// and are checked against an array-based model of the architectural state.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr0_en, wr1_en, iss_en;
    logic [3:0]  wr0_addr, wr1_addr, rs1_addr, rs2_addr, iss_rd;
    logic [15:0] wr0_data, wr1_data;

    logic [15:0] b_rs1, b_rs2, n_rs1, n_rs2;
    logic        b_rs1_busy, b_rs2_busy, b_rd_busy, n_rs1_busy, n_rs2_busy, n_rd_busy;
    logic [15:0] b_vec, n_vec;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_regs [16];
    bit          m_busy [16];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(16), .NREGS(16), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(b_rs1), .rs2_rdata(b_rs2),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy), .rd_busy(b_rd_busy), .busy_vec(b_vec)
    );

    regfile_sb #(.XLEN(16), .NREGS(16), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(n_rs1), .rs2_rdata(n_rs2),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy), .rd_busy(n_rd_busy), .busy_vec(n_vec)
    );

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // Architectural effect of one clock edge given the inputs presented during that cycle.
    function automatic void model_edge();
        bit set_now [16];
        for (int i = 0; i < 16; i++) set_now[i] = 1'b0;
        if (iss_en && iss_rd != 0) set_now[iss_rd] = 1'b1;
        if (wr0_en && wr0_addr != 0) begin
            m_regs[wr0_addr] = wr0_data;
            m_busy[wr0_addr] = 1'b0;
        end
        if (wr1_en && wr1_addr != 0) begin
            m_regs[wr1_addr] = wr1_data;
            m_busy[wr1_addr] = 1'b0;
        end
        for (int i = 1; i < 16; i++) if (set_now[i]) m_busy[i] = 1'b1;
    endfunction

    function automatic logic [15:0] exp_rdata(input logic [3:0] a, input bit byp);
        if (a == 0) return 16'h0000;
        if (byp && wr1_en && wr1_addr == a) return wr1_data;
        if (byp && wr0_en && wr0_addr == a) return wr0_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a))) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle_inputs();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        iss_en = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_clear();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        repeat (2) tick();
        for (int a = 0; a < 16; a++) begin
            rs1_addr = 4'(a);
            rs2_addr = 4'(15 - a);
            #1;
            checks++;
            if (b_rs1 !== 16'h0 || b_rs2 !== 16'h0 || n_rs1 !== 16'h0 || n_rs2 !== 16'h0) begin
                failures++;
                $display("FAIL reset_rdata a=%0d got b=%h/%h nb=%h/%h exp 0", a, b_rs1, b_rs2, n_rs1, n_rs2);
            end
        end
        checks++;
        if (b_vec !== 16'h0 || n_vec !== 16'h0 || b_rd_busy !== 1'b0 || b_rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got vec=%h/%h exp 0", b_vec, n_vec);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        idle_inputs();
        wr0_en = 1; wr0_addr = 3; wr0_data = 16'hA5A5; rs1_addr = 3;
        #1;
        checks++;
        if (b_rs1 !== 16'hA5A5 || n_rs1 !== 16'h0000) begin
            failures++;
            $display("FAIL wr0_same_cycle got b=%h nb=%h exp A5A5/0000", b_rs1, n_rs1);
        end
        tick();
        wr0_addr = 0; wr0_data = 16'hFFFF; rs2_addr = 0;
        #1;
        checks++;
        if (b_rs1 !== 16'hA5A5 || n_rs1 !== 16'hA5A5) begin
            failures++;
            $display("FAIL wr0_next_cycle got b=%h nb=%h exp A5A5", b_rs1, n_rs1);
        end
        checks++;
        if (b_rs2 !== 16'h0 || n_rs2 !== 16'h0) begin
            failures++;
            $display("FAIL r0_bypass got b=%h nb=%h exp 0", b_rs2, n_rs2);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (b_rs2 !== 16'h0 || n_rs2 !== 16'h0) begin
            failures++;
            $display("FAIL r0_stored got b=%h nb=%h exp 0", b_rs2, n_rs2);
        end
    endtask

    task automatic test_same_addr();
        logic [15:0] old5;
        old5 = m_regs[5];
        idle_inputs();
        wr0_en = 1; wr0_addr = 5; wr0_data = 16'h1111;
        wr1_en = 1; wr1_addr = 5; wr1_data = 16'h2222;
        rs1_addr = 5;
        #1;
        checks++;
        if (b_rs1 !== 16'h2222 || n_rs1 !== old5) begin
            failures++;
            $display("FAIL collide_bypass got b=%h nb=%h exp 2222/%h", b_rs1, n_rs1, old5);
        end
        tick();
        idle_inputs();
        rs1_addr = 5;
        #1;
        checks++;
        if (b_rs1 !== 16'h2222 || n_rs1 !== 16'h2222) begin
            failures++;
            $display("FAIL collide_stored got b=%h nb=%h exp 2222", b_rs1, n_rs1);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        iss_en = 1; iss_rd = 7;
        tick();
        idle_inputs();
        rs1_addr = 7; iss_rd = 7;
        #1;
        checks++;
        if (b_vec[7] !== 1'b1 || b_rs1_busy !== 1'b1 || n_rs1_busy !== 1'b1 || b_rd_busy !== 1'b1) begin
            failures++;
            $display("FAIL issue_busy got vec7=%b rs1=%b/%b rd=%b exp 1", b_vec[7], b_rs1_busy, n_rs1_busy, b_rd_busy);
        end
        wr1_en = 1; wr1_addr = 7; wr1_data = 16'h0042;
        #1;
        checks++;
        if (b_rs1_busy !== 1'b0 || b_rs1 !== 16'h0042 || b_rd_busy !== 1'b0) begin
            failures++;
            $display("FAIL wb_bypass got busy=%b rd=%b data=%h exp 0/0/0042", b_rs1_busy, b_rd_busy, b_rs1);
        end
        checks++;
        if (n_rs1_busy !== 1'b1 || b_vec[7] !== 1'b1 || n_rs1 !== m_regs[7]) begin
            failures++;
            $display("FAIL wb_nobypass got busy=%b vec7=%b data=%h exp 1/1/%h", n_rs1_busy, b_vec[7], n_rs1, m_regs[7]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (b_vec[7] !== 1'b0 || n_vec[7] !== 1'b0) begin
            failures++;
            $display("FAIL wb_clear got vec7=%b/%b exp 0", b_vec[7], n_vec[7]);
        end
    endtask

    task automatic test_set_clear_same();
        idle_inputs();
        iss_en = 1; iss_rd = 9;
        wr0_en = 1; wr0_addr = 9; wr0_data = 16'h9C9C;
        tick();
        idle_inputs();
        rs1_addr = 9;
        #1;
        checks++;
        if (b_rs1 !== 16'h9C9C || b_vec[9] !== 1'b1 || n_vec[9] !== 1'b1 || b_rs1_busy !== 1'b1) begin
            failures++;
            $display("FAIL set_wins got data=%h vec9=%b/%b busy=%b exp 9C9C/1/1/1", b_rs1, b_vec[9], n_vec[9], b_rs1_busy);
        end
        checks++;
        if (b_vec[0] !== 1'b0) begin
            failures++;
            $display("FAIL r0_never_busy got %b exp 0", b_vec[0]);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        wr0_en = 1; wr0_addr = 2; wr0_data = 16'hBEEF;
        iss_en = 1; iss_rd = 4;
        tick();
        idle_inputs();
        rs1_addr = 2;
        #1;
        checks++;
        if (b_rs1 !== 16'hBEEF || b_vec[4] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got data=%h vec4=%b exp BEEF/1", b_rs1, b_vec[4]);
        end
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (b_rs1 !== 16'h0 || n_rs1 !== 16'h0 || b_vec !== 16'h0 || n_vec !== 16'h0) begin
            failures++;
            $display("FAIL async_reset got data=%h/%h vec=%h/%h exp 0", b_rs1, n_rs1, b_vec, n_vec);
        end
        wr1_en = 1; wr1_addr = 6; wr1_data = 16'h6666; iss_en = 1; iss_rd = 6;
        tick();
        idle_inputs();
        rs1_addr = 6;
        #1;
        checks++;
        if (b_rs1 !== 16'h0 || b_vec !== 16'h0) begin
            failures++;
            $display("FAIL reset_discards got data=%h vec=%h exp 0", b_rs1, b_vec);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            wr0_en = 1'($urandom_range(0, 1)); wr0_addr = 4'($urandom); wr0_data = 16'($urandom);
            wr1_en = 1'($urandom_range(0, 1)); wr1_addr = 4'($urandom); wr1_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) wr1_addr = wr0_addr;
            iss_en = 1'($urandom_range(0, 1)); iss_rd = 4'($urandom);
            rs1_addr = 4'($urandom); rs2_addr = 4'($urandom);
            if ($urandom_range(0, 2) == 0) rs1_addr = wr1_addr;
            if ($urandom_range(0, 2) == 0) rs2_addr = wr0_addr;
            #2;
            for (int k = 0; k < 2; k++) begin
                bit          byp;
                logic [15:0] g1, g2, gv;
                logic [2:0]  gb, eb;
                byp = (k == 0);
                g1 = byp ? b_rs1 : n_rs1;
                g2 = byp ? b_rs2 : n_rs2;
                gv = byp ? b_vec : n_vec;
                gb = byp ? {b_rs1_busy, b_rs2_busy, b_rd_busy} : {n_rs1_busy, n_rs2_busy, n_rd_busy};
                eb = {exp_busy(rs1_addr, byp), exp_busy(rs2_addr, byp), exp_busy(iss_rd, byp)};
                checks++;
                if (g1 !== exp_rdata(rs1_addr, byp) || g2 !== exp_rdata(rs2_addr, byp)) begin
                    failures++;
                    $display("FAIL rand_rdata cyc=%0d byp=%0d got %h/%h exp %h/%h", c, byp, g1, g2,
                             exp_rdata(rs1_addr, byp), exp_rdata(rs2_addr, byp));
                end
                checks++;
                if (gb !== eb || gv !== exp_vec()) begin
                    failures++;
                    $display("FAIL rand_busy cyc=%0d byp=%0d got %b vec=%h exp %b vec=%h", c, byp, gb, gv, eb, exp_vec());
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_addr();
        test_scoreboard();
        test_set_clear_same();
        test_async_reset();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
